// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one load/store at a time and
// answers after a fixed LATENCY of wait cycles, rejecting misaligned or out-of-range accesses.
module dmem_responder #(
   parameter int WORDS   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        busy,
   output logic        err
);

   localparam int         IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [3:0] LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic          cap_we;
   logic [31:0]   cap_addr;
   logic [31:0]   cap_wdata;
   logic [31:0]   mem [WORDS];

   logic          cur_we;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic          reject;
   logic          enter_resp;
   logic [IW-1:0] idx;

   // With LATENCY=0 RESP is entered on the accepting edge, before the capture
   // registers hold the request, so the live inputs are used while in IDLE.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      cur_we    = cap_we;
      cur_addr  = cap_addr;
      cur_wdata = cap_wdata;
      if (state == IDLE) begin
         cur_we    = we;
         cur_addr  = addr;
         cur_wdata = write_data;
      end
      reject     = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= 32'(WORDS));
      idx        = cur_addr[IW+1:2];
      enter_resp = ((state == WAIT) && (cnt == 4'd0)) ||
                   ((state == IDLE) && req && (LATENCY == 0));
   end

   // NOTE: storage has no reset branch so it maps onto plain RAM; contents survive reset.
   always_ff @(posedge clk) begin
      if (enter_resp && cur_we && !reject)
         mem[idx] <= cur_wdata;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         ready     <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         read_data <= 32'h0;
         cap_we    <= 1'b0;
         cap_addr  <= 32'h0;
         cap_wdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  cap_we    <= we;
                  cap_addr  <= addr;
                  cap_wdata <= write_data;
                  busy      <= 1'b1;
                  if (LATENCY == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= LOAD;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= RESP;
               else             cnt   <= cnt - 4'd1;
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         ready <= enter_resp;
         err   <= enter_resp && reject;
         if (enter_resp && !cur_we)
            read_data <= reject ? 32'h0 : mem[idx];
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: a LATENCY=2 instance and a
// LATENCY=0 instance, each compared against a word-array reference model.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s [2];
   logic        req_s [2];
   logic        we_s  [2];
   logic [31:0] addr_s[2];
   logic [31:0] wd_s  [2];

   logic [31:0] rd0, rd1;
   logic        rdy0, rdy1, bsy0, bsy1, er0, er1;

   dmem_responder #(.WORDS(64), .LATENCY(2)) dut_l2 (
      .clk(clk), .reset(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
      .write_data(wd_s[0]), .read_data(rd0), .ready(rdy0), .busy(bsy0), .err(er0));

   dmem_responder #(.WORDS(64), .LATENCY(0)) dut_l0 (
      .clk(clk), .reset(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
      .write_data(wd_s[1]), .read_data(rd1), .ready(rdy1), .busy(bsy1), .err(er1));

   int checks = 0;
   int errors = 0;

   // Reference model: word storage plus last completed read value per instance.
   logic [31:0] mmem[2][64];
   logic [31:0] mrd [2];

   function automatic int lat(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   function automatic logic [2:0] status(input int u);
      return (u == 0) ? {bsy0, rdy0, er0} : {bsy1, rdy1, er1};
   endfunction

   function automatic logic [31:0] rdata(input int u);
      return (u == 0) ? rd0 : rd1;
   endfunction

   function automatic bit rejected(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
   endfunction

   task automatic apply_model(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                              output bit rej);
      rej = rejected(a);
      if (w && !rej) mmem[u][a[7:2]] = d;
      if (!w)        mrd[u] = rej ? 32'h0 : mmem[u][a[7:2]];
   endtask

   task automatic drive(input int u, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      req_s[u] = r; we_s[u] = w; addr_s[u] = a; wd_s[u] = d;
   endtask

   task automatic junk(input int u);
      drive(u, 1'($urandom), 1'($urandom), $urandom, $urandom);
   endtask

   // One isolated request; inputs are scrambled while the request is in flight.
   task automatic transact(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input string tag);
      int          l = lat(u);
      logic [31:0] old_rd = mrd[u];
      bit          rej;
      logic [2:0]  exp_st;
      logic [31:0] exp_rd;
      apply_model(u, w, a, d, rej);
      @(negedge clk);
      drive(u, 1'b1, w, a, d);
      @(posedge clk);
      for (int k = 0; k <= l; k++) begin
         @(negedge clk);
         exp_st = {1'b1, (k == l), (k == l) && rej};
         exp_rd = (k == l) ? mrd[u] : old_rd;
         checks++;
         if (status(u) !== exp_st) begin
            errors++;
            $display("FAIL %s status u%0d cyc%0d: busy/ready/err got %b expected %b", tag, u, k, status(u), exp_st);
         end
         checks++;
         if (rdata(u) !== exp_rd) begin
            errors++;
            $display("FAIL %s read_data u%0d cyc%0d: got %h expected %h", tag, u, k, rdata(u), exp_rd);
         end
         if (k < l) junk(u);
         else       req_s[u] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (status(u) !== 3'b000) begin
         errors++;
         $display("FAIL %s idle u%0d: busy/ready/err got %b expected 000", tag, u, status(u));
      end
   endtask

   task automatic test_reset;
      for (int u = 0; u < 2; u++) begin
         rst_s[u] = 1'b0;
         drive(u, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      mrd[0] = 32'h0;
      mrd[1] = 32'h0;
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         checks++;
         if (status(u) !== 3'b000 || rdata(u) !== 32'h0) begin
            errors++;
            $display("FAIL reset u%0d: status %b read_data %h expected 000 and 0", u, status(u), rdata(u));
         end
         rst_s[u] = 1'b1;
      end
   endtask

   task automatic test_fill(input int u);
      for (int i = 0; i < 64; i++)
         transact(u, 1'b1, 32'(i * 4), $urandom, "fill");
   endtask

   task automatic test_directed;
      transact(0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
      transact(0, 1'b0, 32'h10, 32'h0, "rd_10");
      checks++;
      if (rd0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_10_value: got %h expected deadbeef", rd0);
      end
      transact(0, 1'b1, 32'h14, 32'h0BADF00D, "wr_14_hold");
      checks++;
      if (rd0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL hold_after_write: got %h expected deadbeef", rd0);
      end
      transact(0, 1'b1, 32'h13, 32'h55555555, "wr_misaligned");
      transact(0, 1'b0, 32'h100, 32'h0, "rd_out_of_range");
      checks++;
      if (rd0 !== 32'h0) begin
         errors++;
         $display("FAIL oor_read_zero: got %h expected 00000000", rd0);
      end
      transact(0, 1'b0, 32'h10, 32'h0, "rd_10_again");
      checks++;
      if (rd0 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL mem4_unchanged: got %h expected deadbeef", rd0);
      end
   endtask

   // req held high with alternating write/read to 0x20: one completion every LATENCY+2 cycles.
   task automatic test_back_to_back(input int u, input int n);
      int          l = lat(u);
      int          since;
      int          done = 0;
      logic        cur_w = 1'b1;
      logic [31:0] cur_d = $urandom;
      bit          rej;
      bit          exp_ready;
      logic [2:0]  exp_st;
      @(negedge clk);
      drive(u, 1'b1, cur_w, 32'h20, cur_d);
      since = 1;
      while (done < n) begin
         @(negedge clk);
         since++;
         exp_ready = (since == l + 2);
         rej = 1'b0;
         if (exp_ready) apply_model(u, cur_w, 32'h20, cur_d, rej);
         exp_st = {(since >= 2), exp_ready, exp_ready && rej};
         checks++;
         if (status(u) !== exp_st) begin
            errors++;
            $display("FAIL b2b status u%0d req%0d since%0d: got %b expected %b", u, done, since, status(u), exp_st);
         end
         checks++;
         if (rdata(u) !== mrd[u]) begin
            errors++;
            $display("FAIL b2b read_data u%0d req%0d: got %h expected %h", u, done, rdata(u), mrd[u]);
         end
         if (exp_ready) begin
            done++;
            since = 0;
            cur_w = ~cur_w;
            cur_d = $urandom;
            if (done < n) drive(u, 1'b1, cur_w, 32'h20, cur_d);
            else          req_s[u] = 1'b0;
         end else if (since >= 2) begin
            junk(u);
         end
      end
      @(negedge clk);
      checks++;
      if (status(u) !== 3'b000) begin
         errors++;
         $display("FAIL b2b end idle u%0d: got %b expected 000", u, status(u));
      end
   endtask

   // Reset pulsed in the second WAIT cycle of a write aborts it without touching storage.
   task automatic test_reset_abort;
      @(negedge clk);
      drive(0, 1'b1, 1'b1, 32'h08, 32'h1234);
      @(posedge clk);
      @(negedge clk);
      req_s[0] = 1'b0;
      @(posedge clk);
      #2 rst_s[0] = 1'b0;
      mrd[0] = 32'h0;
      #1;
      checks++;
      if (status(0) !== 3'b000 || rd0 !== 32'h0) begin
         errors++;
         $display("FAIL abort_immediate: status %b read_data %h expected 000 and 0", status(0), rd0);
      end
      @(negedge clk);
      rst_s[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (status(0) !== 3'b000) begin
            errors++;
            $display("FAIL abort_no_ready cyc%0d: got %b expected 000", k, status(0));
         end
      end
      transact(0, 1'b0, 32'h08, 32'h0, "rd_08_after_abort");
   endtask

   task automatic test_random(input int u, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 9))
            0:       a = {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
            1:       a = 32'h100 + ($urandom & 32'h0FFF_FFFC);
            default: a = 32'($urandom_range(0, 63)) << 2;
         endcase
         transact(u, 1'($urandom), a, $urandom, "random");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill(0);
      test_fill(1);
      test_directed();
      test_back_to_back(0, 6);
      test_reset_abort();
      test_random(0, 40);
      transact(1, 1'b0, 32'h10, 32'h0, "l0_read");
      test_random(1, 40);
      test_back_to_back(1, 6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
